// File: rtl/bus_grant_scheduler.sv
// Two-master, three-slave serial ADS bus grant scheduler: round-robin arbitration,
// serial slave-select decode, slave-ready wait and one-hot route enables.
module bus_grant_scheduler #(
  parameter int unsigned SEL_BITS = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m1_request,
  input  logic       m2_request,
  input  logic       m1_address,
  input  logic       m2_address,
  input  logic       m1_address_valid,
  input  logic       m2_address_valid,
  input  logic [2:0] s_ready,
  output logic       m1_available,
  output logic       m2_available,
  output logic       owner,
  output logic [1:0] slave_sel,
  output logic [2:0] route_en,
  output logic       timeout_err,
  output logic       decode_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StAddr      = 3'd1,
    StWaitSlave = 3'd2,
    StConnect   = 3'd3,
    StRelease   = 3'd4
  } state_e;

  localparam int unsigned    CntW     = $clog2(SEL_BITS + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(SEL_BITS - 1);
  localparam logic [7:0]     TmoLimit = 8'(TIMEOUT);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [1:0]          slave_sel_q, slave_sel_d;
  logic [2:0]          route_en_q, route_en_d;
  logic                timeout_err_q, timeout_err_d;
  logic                decode_err_q, decode_err_d;
  logic [SEL_BITS-1:0] shift_q, shift_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]          tmo_q, tmo_d;

  logic                own_req, own_valid, own_addr;
  logic                tmo_hit, sel_ready;
  logic [7:0]          tmo_inc;
  logic [SEL_BITS-1:0] shift_in;
  logic [1:0]          sel_in;
  logic [2:0]          sel_onehot;

  assign own_req    = owner_q ? m2_request       : m1_request;
  assign own_valid  = owner_q ? m2_address_valid : m1_address_valid;
  assign own_addr   = owner_q ? m2_address       : m1_address;
  assign shift_in   = (shift_q << 1) | SEL_BITS'(own_addr);
  assign sel_in     = 2'(shift_in);
  // Code 11 shifts out of the 3-bit vector, so it can never look ready.
  assign sel_onehot = 3'b001 << slave_sel_q;
  assign sel_ready  = |(s_ready & sel_onehot);
  // Counter saturates; the limit is hit on the cycle the increment would reach TIMEOUT.
  assign tmo_inc    = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
  assign tmo_hit    = (tmo_q >= TmoLimit - 8'd1);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    slave_sel_d   = slave_sel_q;
    route_en_d    = route_en_q;
    timeout_err_d = 1'b0;
    decode_err_d  = 1'b0;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    tmo_d         = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (m1_request || m2_request) begin
          state_d   = StAddr;
          owner_d   = (m1_request && m2_request) ? ~owner_q : m2_request;
          shift_d   = '0;
          bit_cnt_d = '0;
          tmo_d     = '0;
        end
      end
      StAddr: begin
        if (!own_req) begin
          state_d = StRelease;
        end else if (own_valid) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + CntW'(1);
          if (bit_cnt_q == LastBit) begin
            slave_sel_d = sel_in;
            if (sel_in == 2'b11) begin
              state_d      = StRelease;
              decode_err_d = 1'b1;
            end else begin
              state_d = StWaitSlave;
              tmo_d   = '0;
            end
          end
        end else begin
          tmo_d = tmo_inc;
          if (tmo_hit) begin
            state_d       = StRelease;
            timeout_err_d = 1'b1;
          end
        end
      end
      StWaitSlave: begin
        if (!own_req) begin
          state_d = StRelease;
        end else if (tmo_hit) begin
          tmo_d         = tmo_inc;
          state_d       = StRelease;
          timeout_err_d = 1'b1;
        end else if (sel_ready) begin
          state_d    = StConnect;
          route_en_d = sel_onehot;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      StConnect: begin
        if (!own_req) begin
          state_d    = StRelease;
          route_en_d = '0;
        end
      end
      StRelease: begin
        state_d   = StIdle;
        bit_cnt_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      owner_q       <= 1'b1;
      slave_sel_q   <= '0;
      route_en_q    <= '0;
      timeout_err_q <= 1'b0;
      decode_err_q  <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      slave_sel_q   <= slave_sel_d;
      route_en_q    <= route_en_d;
      timeout_err_q <= timeout_err_d;
      decode_err_q  <= decode_err_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      tmo_q         <= tmo_d;
    end
  end

  logic granted;
  assign granted      = (state_q == StAddr) || (state_q == StWaitSlave) ||
                        (state_q == StConnect);
  assign m1_available = granted && !owner_q;
  assign m2_available = granted && owner_q;
  assign owner        = owner_q;
  assign slave_sel    = slave_sel_q;
  assign route_en     = route_en_q;
  assign timeout_err  = timeout_err_q;
  assign decode_err   = decode_err_q;
  assign state        = 3'(state_q);

endmodule

// File: tb/tb_bus_grant_scheduler.sv
// Self-checking bench for bus_grant_scheduler: per-scenario tasks with a scoreboard of
// expected transaction outcomes (connect route, decode error, timeout).
module tb_bus_grant_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       m1_request, m2_request, m1_address, m2_address;
  logic       m1_address_valid, m2_address_valid;
  logic [2:0] s_ready;
  logic       m1_available, m2_available, owner, timeout_err, decode_err;
  logic [1:0] slave_sel;
  logic [2:0] route_en, state;

  typedef struct packed {
    logic [1:0] kind;   // 0 connect, 1 decode error, 2 timeout
    logic       owner;
    logic [2:0] route;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  bus_grant_scheduler #(.SEL_BITS(2), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .m1_request(m1_request), .m2_request(m2_request),
    .m1_address(m1_address), .m2_address(m2_address),
    .m1_address_valid(m1_address_valid), .m2_address_valid(m2_address_valid),
    .s_ready(s_ready),
    .m1_available(m1_available), .m2_available(m2_available), .owner(owner),
    .slave_sel(slave_sel), .route_en(route_en), .timeout_err(timeout_err),
    .decode_err(decode_err), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk_exp(input logic [1:0] k, input logic o, input logic [2:0] r);
    exp_t e;
    e.kind  = k;
    e.owner = o;
    e.route = r;
    return e;
  endfunction

  task automatic clear_inputs();
    m1_request = 0; m2_request = 0; m1_address = 0; m2_address = 0;
    m1_address_valid = 0; m2_address_valid = 0; s_ready = 3'b000;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  // Serially send a 2-bit select MSB first on master m (0=m1, 1=m2).
  task automatic send_sel(input logic m, input logic [1:0] code);
    for (int i = 0; i < 2; i++) begin
      if (!m) begin m1_address_valid = 1; m1_address = code[1-i]; end
      else    begin m2_address_valid = 1; m2_address = code[1-i]; end
      tick();
    end
    if (!m) m1_address_valid = 0; else m2_address_valid = 0;
  endtask

  task automatic sb_check(input string name);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got kind=%0d owner=%0d route=%b with no expected entry",
               name, {timeout_err, decode_err}, owner, route_en);
    end else begin
      e = sb_q.pop_front();
      if ({timeout_err, decode_err, owner, route_en} !== {e.kind, e.owner, e.route}) begin
        n_fail++;
        $display("FAIL %s: got kind=%0d owner=%0d route=%b expected kind=%0d owner=%0d route=%b",
                 name, {timeout_err, decode_err}, owner, route_en, e.kind, e.owner, e.route);
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    m1_request = 1; m2_request = 1;
    reset = 0;
    tick();
    tick();
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", state); end
    n_checks++;
    if (owner !== 1'b1) begin n_fail++; $display("FAIL rst_owner: got %0d expected 1", owner); end
    n_checks++;
    if ({m1_available, m2_available, slave_sel, route_en, timeout_err, decode_err} !== 9'b0) begin
      n_fail++;
      $display("FAIL rst_outputs: got %b expected 0", {m1_available, m2_available, slave_sel,
               route_en, timeout_err, decode_err});
    end
    m1_request = 0; m2_request = 0;
    reset = 1;
    tick();
    n_checks++;
    if ({m1_available, m2_available, owner, slave_sel, route_en, timeout_err, decode_err, state}
        !== 14'b00_1_00_000_0_0_000) begin
      n_fail++;
      $display("FAIL rst_idle: got %b expected 00100000000000", {m1_available, m2_available,
               owner, slave_sel, route_en, timeout_err, decode_err, state});
    end
  endtask

  task automatic test_single_grant();
    s_ready = 3'b010;
    m1_request = 1;
    sb_q.push_back(mk_exp(2'd0, 1'b0, 3'b010));
    tick();
    n_checks++;
    if ({m1_available, m2_available, state} !== 5'b10_001) begin
      n_fail++;
      $display("FAIL grant_latency: got av=%b state=%0d expected av=10 state=1",
               {m1_available, m2_available}, state);
    end
    send_sel(1'b0, 2'b01);
    n_checks++;
    if ({state, slave_sel, route_en} !== {3'd2, 2'b01, 3'b000}) begin
      n_fail++;
      $display("FAIL addr_decode: got state=%0d sel=%b route=%b expected 2/01/000",
               state, slave_sel, route_en);
    end
    tick();
    n_checks++;
    if (state !== 3'd3) begin n_fail++; $display("FAIL connect_state: got %0d expected 3", state); end
    sb_check("connect_m1_s2");
    tick();
    tick();
    n_checks++;
    if ({m1_available, route_en} !== 4'b1_010) begin
      n_fail++;
      $display("FAIL connect_hold: got av=%b route=%b expected 1/010", m1_available, route_en);
    end
    m1_request = 0;
    tick();
    n_checks++;
    if ({state, m1_available, m2_available, route_en} !== {3'd4, 5'b0}) begin
      n_fail++;
      $display("FAIL release: got state=%0d av=%b route=%b expected 4/00/000",
               state, {m1_available, m2_available}, route_en);
    end
    tick();
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL back_idle: got %0d expected 0", state); end
  endtask

  task automatic test_back_to_back();
    int rel_cnt, overlap, n;
    apply_reset();
    s_ready = 3'b111;
    m1_request = 1; m2_request = 1;
    sb_q.push_back(mk_exp(2'd0, 1'b0, 3'b001));
    sb_q.push_back(mk_exp(2'd0, 1'b1, 3'b100));
    tick();
    n_checks++;
    if ({m1_available, m2_available, owner} !== 3'b10_0) begin
      n_fail++;
      $display("FAIL tie_first: got av=%b owner=%0d expected 10/0",
               {m1_available, m2_available}, owner);
    end
    // Non-owner address traffic must be ignored.
    m2_address_valid = 1; m2_address = 1;
    send_sel(1'b0, 2'b00);
    m2_address_valid = 0;
    n_checks++;
    if ({state, slave_sel} !== {3'd2, 2'b00}) begin
      n_fail++;
      $display("FAIL nonowner_ignored: got state=%0d sel=%b expected 2/00", state, slave_sel);
    end
    tick();
    sb_check("connect_m1_s1");
    m1_request = 0;
    rel_cnt = 0; overlap = 0; n = 0;
    tick();
    while (!m2_available && n < 10) begin
      if (state == 3'd4) rel_cnt++;
      if (m1_available) overlap++;
      tick();
      n++;
    end
    n_checks++;
    if ({m2_available, owner} !== 2'b11) begin
      n_fail++;
      $display("FAIL tie_second: got m2_av=%0d owner=%0d expected 1/1", m2_available, owner);
    end
    n_checks++;
    if (rel_cnt !== 1 || overlap !== 0) begin
      n_fail++;
      $display("FAIL turnaround: got release=%0d overlap=%0d expected 1/0", rel_cnt, overlap);
    end
    m1_request = 1;
    send_sel(1'b1, 2'b10);
    tick();
    sb_check("connect_m2_s3");
    tick();
    tick();
    n_checks++;
    if ({m1_available, m2_available, owner, route_en} !== 6'b01_1_100) begin
      n_fail++;
      $display("FAIL no_preempt: got av=%b owner=%0d route=%b expected 01/1/100",
               {m1_available, m2_available}, owner, route_en);
    end
    m2_request = 0;
    tick();
    tick();
    tick();
    n_checks++;
    if ({m1_available, owner, state} !== 5'b1_0_001) begin
      n_fail++;
      $display("FAIL regrant_m1: got av=%0d owner=%0d state=%0d expected 1/0/1",
               m1_available, owner, state);
    end
    m1_request = 0;
    tick();
    tick();
  endtask

  task automatic test_decode_err();
    int de_cnt;
    m2_request = 1;
    sb_q.push_back(mk_exp(2'd1, 1'b1, 3'b000));
    tick();
    send_sel(1'b1, 2'b11);
    n_checks++;
    if (state !== 3'd4) begin n_fail++; $display("FAIL decode_release: got %0d expected 4", state); end
    sb_check("decode_11");
    m2_request = 0;
    de_cnt = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (decode_err) de_cnt++;
    end
    n_checks++;
    if (de_cnt !== 1 || state !== 3'd0 || route_en !== 3'b000) begin
      n_fail++;
      $display("FAIL decode_pulse: got pulses=%0d state=%0d route=%b expected 1/0/000",
               de_cnt, state, route_en);
    end
  endtask

  task automatic test_timeout();
    int cnt;
    s_ready = 3'b011;
    m1_request = 1;
    sb_q.push_back(mk_exp(2'd2, 1'b0, 3'b000));
    tick();
    send_sel(1'b0, 2'b10);
    n_checks++;
    if (slave_sel !== 2'b10) begin n_fail++; $display("FAIL tmo_sel: got %b expected 10", slave_sel); end
    cnt = 0;
    while (state == 3'd2 && cnt < 400) begin
      cnt++;
      tick();
    end
    n_checks++;
    if (cnt !== 255) begin n_fail++; $display("FAIL tmo_cycles: got %0d expected 255", cnt); end
    n_checks++;
    if (state !== 3'd4) begin n_fail++; $display("FAIL tmo_release: got %0d expected 4", state); end
    sb_check("timeout");
    m1_request = 0;
    tick();
    n_checks++;
    if ({state, timeout_err} !== 4'b000_0) begin
      n_fail++;
      $display("FAIL tmo_after: got state=%0d terr=%0d expected 0/0", state, timeout_err);
    end
  endtask

  task automatic test_abort();
    s_ready = 3'b010;
    m1_request = 1;
    sb_q.push_back(mk_exp(2'd0, 1'b0, 3'b010));
    tick();
    send_sel(1'b0, 2'b01);
    tick();
    sb_check("connect_before_reset");
    reset = 0;
    tick();
    n_checks++;
    if ({m1_available, m2_available, owner, slave_sel, route_en, timeout_err, decode_err, state}
        !== 14'b00_1_00_000_0_0_000) begin
      n_fail++;
      $display("FAIL reset_connect: got %b expected 00100000000000", {m1_available, m2_available,
               owner, slave_sel, route_en, timeout_err, decode_err, state});
    end
    reset = 1;
    m1_request = 0;
    tick();
    m1_request = 1;
    tick();
    m1_address_valid = 1; m1_address = 1;
    tick();
    m1_address_valid = 0;
    m1_request = 0;
    tick();
    n_checks++;
    if ({state, timeout_err, decode_err} !== 5'b100_0_0) begin
      n_fail++;
      $display("FAIL abort_addr: got state=%0d errs=%b expected 4/00", state,
               {timeout_err, decode_err});
    end
    tick();
    m1_request = 1;
    tick();
    m1_address_valid = 1; m1_address = 1;
    tick();
    // Second select bit completes code 11 on the same cycle the request drops.
    m1_request = 0;
    tick();
    m1_address_valid = 0;
    n_checks++;
    if ({state, decode_err} !== 4'b100_0) begin
      n_fail++;
      $display("FAIL abort_priority: got state=%0d derr=%0d expected 4/0", state, decode_err);
    end
    tick();
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL abort_idle: got %0d expected 0", state); end
  endtask

  initial begin
    clear_inputs();
    reset = 0;
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_decode_err();
    test_timeout();
    test_abort();
    n_checks++;
    if (sb_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
